stopwatch_control: RTL and testbench
====================================

// Module: stopwatch_control
//
// PURPOSE
//   Run-control and timebase stage that sits directly upstream of the digit counter chain.
//   Conditions the raw start/pause buttons and runs an IDLE/RUN/PAUSED state machine.
//   Emits the 1-cycle count tick that enables the least-significant timer digit.
//   Emits a clear pulse that zeroes the timers without a hard reset.
//
// PARAMETERS
//   TICK_DIV      50_000_000  clk cycles per tick (1 Hz at 50 MHz); legal range >= 2
//   DEBOUNCE_CYC  1_000_000   stable-input cycles needed before a press is accepted (STOPWATCH_DEBOUNCE_EN only)
//
// PORTS
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active-low
//   start    in   1  raw start/resume button, active-high, asynchronous to clk
//   pause    in   1  raw pause/clear button, active-high, asynchronous to clk
//   tick     out  1  1-cycle pulse every TICK_DIV cycles while in RUN; drives timer enable
//   clear    out  1  1-cycle pulse on PAUSED->IDLE; synchronous clear for the timers
//   running  out  1  high while state == RUN
//   paused   out  1  high while state == PAUSED
//
// BEHAVIOUR
//   Reset (rst==0, async)
//     - state=IDLE; prescaler=0; all conditioner flops=0.
//     - Outputs tick=0, clear=0, running=0, paused=0.
//     - Mid-run reset drops everything immediately; the prescaler phase is lost.
//   Button conditioning
//     - Each button passes through a 2-FF synchronizer, then a rising-edge detector -> press event (1 cycle).
//     - Without debounce, the state changes on the 3rd rising clk edge after the raw input goes high.
//     - Holding a button produces exactly one event; a new event needs a release first.
//   State machine (transitions on press events)
//     - IDLE   + start -> RUN
//     - RUN    + pause -> PAUSED
//     - PAUSED + start -> RUN (resume)
//     - PAUSED + pause -> IDLE, with clear=1 in the cycle the state updates
//     - All other events are ignored, e.g. start in RUN, pause in IDLE.
//     - Simultaneous start+pause events in the same cycle: pause wins.
//   Prescaler, width $clog2(TICK_DIV)
//     - RUN: increments every cycle; at TICK_DIV-1, tick=1 and the count wraps to 0.
//     - PAUSED: holds its value, so the sub-second phase is preserved across pause/resume.
//     - IDLE: forced to 0, so the first tick arrives exactly TICK_DIV cycles after entering RUN.
//   Timing of outputs
//     - tick is a registered decode of (state==RUN && cnt==TICK_DIV-1), using the current registered state.
//     - A pause event in the terminal cycle still allows that tick.
//     - running and paused are state decodes, never both 1.
//     - clear and tick are never high together.
//
// CONFIGURATION
//   STOPWATCH_DEBOUNCE_EN defined
//     - After the synchronizer, a counter requires the synced level to differ from the filtered level
//       for DEBOUNCE_CYC consecutive cycles before the filtered level flips.
//     - The edge detector works on the filtered level.
//     - Any bounce restarts the count.
//     - Press latency = 3 + DEBOUNCE_CYC cycles.
//   Not defined
//     - No filter logic; the edge detector reads the synchronizer output directly.
//     - DEBOUNCE_CYC is ignored.
//
// STRUCTURE
//   stopwatch_pkg
//     - typedef enum logic [1:0] sw_state_t {SW_IDLE=2'b00, SW_RUN=2'b01, SW_PAUSED=2'b10}.
//     - Function for the prescaler width.
//   Sub-module button_conditioner (sync, optional debounce, edge detect); two instances (start, pause).
//   Top level holds the FSM, prescaler and output registers.
//
// TESTING (TICK_DIV=4, DEBOUNCE_CYC=3)
//   1. Reset then idle 20 cycles -> tick=0, clear=0, running=0, paused=0 throughout.
//   2. Pulse start (held 2 cycles)
//      -> running=1 on the 3rd edge; tick pulses every 4 cycles, first 4 cycles after entry.
//   3. RUN for 6 cycles (cnt=2), pause, wait 10 cycles, start
//      -> no tick while paused; first tick 1 cycle after re-entry to RUN (phase held).
//   4. PAUSED, then pause press -> exactly one clear pulse; state IDLE; cnt=0; a new start gives its first tick after 4 cycles.
//   5. start and pause asserted on the same cycle from PAUSED -> IDLE with clear; held button -> single event only.
//   6. With STOPWATCH_DEBOUNCE_EN: a 2-cycle glitch is ignored; a 5-cycle press is accepted after 6 cycles.
//      Also: rst low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch run-control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE   = 2'b00,
    SW_RUN    = 2'b01,
    SW_PAUSED = 2'b10
  } sw_state_t;

  // Bits needed to hold counts 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_control_button_conditioner.sv
// Button conditioner: 2-FF synchronizer, optional debounce filter
// (enabled by STOPWATCH_DEBOUNCE_EN), then a rising-edge detector.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DbW = cnt_width(DEBOUNCE_CYC);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  logic           filt_q;
  logic           filt_d;
  logic [DbW-1:0] db_q;
  logic [DbW-1:0] db_d;

  // Any cycle where the synced level agrees with the filter restarts the count.
  always_comb begin
    filt_d = filt_q;
    db_d   = '0;
    if (sync2_q != filt_q) begin
      if (db_q == DbLast) begin
        filt_d = sync2_q;
      end else begin
        db_d = db_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      db_q   <= '0;
    end else begin
      filt_q <= filt_d;
      db_q   <= db_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign press_o = level & ~prev_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch run control: IDLE/RUN/PAUSED FSM, tick prescaler and clear pulse.
// Optional button debounce is selected with STOPWATCH_DEBOUNCE_EN.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pause,
  output logic tick,
  output logic clear,
  output logic running,
  output logic paused
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end

  localparam int CntW = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic            start_evt;
  logic            pause_evt;
  sw_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic            tick_q;
  logic            clear_q;
  logic            running_q;
  logic            paused_q;

  button_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_start_cond (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (start),
    .press_o(start_evt)
  );

  button_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_pause_cond (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (pause),
    .press_o(pause_evt)
  );

  // Tick decodes the current state, so a pause landing on the terminal count keeps its tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SW_IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      tick_q  <= (state_q == SW_RUN) && (cnt_q == CntLast);
      clear_q <= 1'b0;
      unique case (state_q)
        SW_IDLE: begin
          cnt_q <= '0;
          if (start_evt && !pause_evt) begin
            state_q   <= SW_RUN;
            running_q <= 1'b1;
          end
        end
        SW_RUN: begin
          cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
          if (pause_evt) begin
            state_q   <= SW_PAUSED;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end
        end
        SW_PAUSED: begin
          if (pause_evt) begin
            state_q  <= SW_IDLE;
            cnt_q    <= '0;
            clear_q  <= 1'b1;
            paused_q <= 1'b0;
          end else if (start_evt) begin
            state_q   <= SW_RUN;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= SW_IDLE;
          cnt_q     <= '0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign clear   = clear_q;
  assign running = running_q;
  assign paused  = paused_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with TICK_DIV=4, DEBOUNCE_CYC=3.
module tb_stopwatch_control;

  localparam int TD = 4;
  localparam int DB = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT  = 3 + DB;
  localparam int HOLD = DB + 2;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pause;
  logic tick;
  logic clear;
  logic running;
  logic paused;

  int errors = 0;
  int checks = 0;

  stopwatch_control #(
    .TICK_DIV    (TD),
    .DEBOUNCE_CYC(DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .tick   (tick),
    .clear  (clear),
    .running(running),
    .paused (paused)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output vector order: {running, paused, tick, clear}
  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({running, paused, tick, clear} !== 4'b0000) begin
      errors++; $display("FAIL reset_hold: got %b want 0000", {running, paused, tick, clear});
    end
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0000) begin
        errors++; $display("FAIL idle step %0d: got %b want 0000", i, {running, paused, tick, clear});
      end
    end
    pause = 1'b1;
    for (int i = 1; i <= LAT + 9; i++) begin
      step();
      if (i == HOLD) pause = 1'b0;
      exp = 4'b0000;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL pause_in_idle step %0d: got %b want %b", i, {running, paused, tick, clear}, exp);
      end
    end
  endtask

  task automatic test_start();
    logic [3:0] exp;
    start = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == HOLD) start = 1'b0;
      exp = (k == LAT) ? 4'b1000 : 4'b0000;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL start_lat step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    for (int i = 1; i <= 2 * TD; i++) begin
      step();
      exp = {1'b1, 1'b0, (i % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL tick_period step %0d: got %b want %b", i, {running, paused, tick, clear}, exp);
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [3:0] exp;
    int s;
    int j;
    s = ((3 - LAT) % TD + TD) % TD;
    for (int i = 1; i <= s; i++) begin
      step();
      exp = {1'b1, 1'b0, (i % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL pr_run step %0d: got %b want %b", i, {running, paused, tick, clear}, exp);
      end
    end
    pause = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == HOLD) pause = 1'b0;
      j = s + k;
      exp = (k == LAT) ? {1'b0, 1'b1, (j % TD == 0), 1'b0} : {1'b1, 1'b0, (j % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL pr_pause step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0100) begin
        errors++; $display("FAIL pr_hold step %0d: got %b want 0100", i, {running, paused, tick, clear});
      end
    end
    start = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      if (k == HOLD) start = 1'b0;
      exp = (k < LAT) ? 4'b0100 : (k == LAT) ? 4'b1000 : 4'b1010;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL pr_resume step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] exp;
    int s;
    int j;
    s = ((3 - LAT) % TD + TD) % TD;
    for (int i = 1; i <= s; i++) begin
      step();
      exp = {1'b1, 1'b0, (i % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL clr_run step %0d: got %b want %b", i, {running, paused, tick, clear}, exp);
      end
    end
    pause = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      step();
      if (k == HOLD) pause = 1'b0;
      j = s + k;
      exp = (k < LAT) ? {1'b1, 1'b0, (j % TD == 0), 1'b0} : 4'b0100;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL clr_pause step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    pause = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      step();
      if (k == HOLD) pause = 1'b0;
      exp = (k < LAT) ? 4'b0100 : (k == LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL clr_pulse step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    start = 1'b1;
    for (int k = 1; k <= LAT + TD; k++) begin
      step();
      if (k == HOLD) start = 1'b0;
      exp = (k < LAT) ? 4'b0000 : {1'b1, 1'b0, (k == LAT + TD), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL clr_restart step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
  endtask

  task automatic test_terminal_pause();
    logic [3:0] exp;
    int s;
    int j;
    s = ((TD - LAT) % TD + TD) % TD;
    for (int i = 1; i <= s; i++) begin
      step();
      exp = {1'b1, 1'b0, (i % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL term_run step %0d: got %b want %b", i, {running, paused, tick, clear}, exp);
      end
    end
    pause = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      step();
      if (k == HOLD) pause = 1'b0;
      j = s + k;
      exp = (k < LAT) ? {1'b1, 1'b0, (j % TD == 0), 1'b0} : (k == LAT) ? 4'b0110 : 4'b0100;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL term_pause step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int n;
    start = 1'b1; pause = 1'b1;
    for (int k = 1; k <= LAT + 10; k++) begin
      step();
      exp = (k < LAT) ? 4'b0100 : (k == LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL both_held step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    start = 1'b0; pause = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0000) begin
        errors++; $display("FAIL both_release step %0d: got %b want 0000", i, {running, paused, tick, clear});
      end
    end
    start = 1'b1;
    for (int k = 1; k <= LAT + 10; k++) begin
      step();
      exp = {(k >= LAT), 1'b0, (k > LAT && (k - LAT) % TD == 0), 1'b0};
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL start_held step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    start = 1'b0; pause = 1'b1;
    for (int m = 1; m <= LAT + 10; m++) begin
      step();
      n = 10 + m;
      exp = (m < LAT) ? {1'b1, 1'b0, (n % TD == 0), 1'b0} :
            (m == LAT) ? {1'b0, 1'b1, (n % TD == 0), 1'b0} : 4'b0100;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL pause_held step %0d: got %b want %b", m, {running, paused, tick, clear}, exp);
      end
    end
    pause = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0100) begin
        errors++; $display("FAIL pause_release step %0d: got %b want 0100", i, {running, paused, tick, clear});
      end
    end
  endtask

`ifdef STOPWATCH_DEBOUNCE_EN
  task automatic test_debounce();
    logic [3:0] exp;
    pause = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 2) pause = 1'b0;
      checks++;
      if ({running, paused, tick, clear} !== 4'b0100) begin
        errors++; $display("FAIL glitch step %0d: got %b want 0100", i, {running, paused, tick, clear});
      end
    end
    pause = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      if (k == 5) pause = 1'b0;
      exp = (k < LAT) ? 4'b0100 : (k == LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if ({running, paused, tick, clear} !== exp) begin
        errors++; $display("FAIL db_press step %0d: got %b want %b", k, {running, paused, tick, clear}, exp);
      end
    end
    for (int i = 1; i <= 14; i++) begin
      start = (i % 3 != 0);
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0000) begin
        errors++; $display("FAIL bounce step %0d: got %b want 0000", i, {running, paused, tick, clear});
      end
    end
    start = 1'b0;
    repeat (8) step();
  endtask
`endif

  task automatic test_async_reset();
    bit seen;
    start = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      if (k == HOLD) start = 1'b0;
    end
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL ar_running: got %b want 1", running);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * TD && !seen; i++) begin
      step();
      seen = (tick === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ar_tick_seen: got 0 want 1");
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({running, paused, tick, clear} !== 4'b0000) begin
      errors++; $display("FAIL ar_async: got %b want 0000", {running, paused, tick, clear});
    end
    step();
    step();
    checks++;
    if ({running, paused, tick, clear} !== 4'b0000) begin
      errors++; $display("FAIL ar_held: got %b want 0000", {running, paused, tick, clear});
    end
    rst = 1'b1;
    for (int i = 1; i <= TD + 4; i++) begin
      step();
      checks++;
      if ({running, paused, tick, clear} !== 4'b0000) begin
        errors++; $display("FAIL ar_after step %0d: got %b want 0000", i, {running, paused, tick, clear});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_clear();
    test_terminal_pause();
    test_back_to_back();
`ifdef STOPWATCH_DEBOUNCE_EN
    test_debounce();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
